// File: rtl/stall_pkg.sv
// Shared definitions for the pipeline stall controller: FSM encodings,
// multi-cycle op codes and default geometry.
package stall_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LD   = 2'd1,
    ST_MC   = 2'd2,
    ST_EXT  = 2'd3
  } stall_state_t;

  localparam logic MC_OP_MUL = 1'b0;
  localparam logic MC_OP_DIV = 1'b1;

  localparam int DEF_REG_AW  = 4;
  localparam int DEF_MUL_CYC = 4;
  localparam int DEF_DIV_CYC = 16;
  localparam int DEF_CNT_W   = 5;
  localparam int DEF_PERF_W  = 16;

endpackage

// File: rtl/stall_ctrl_hazard_detect.sv
// Load-use hazard detector between execute and decode; purely combinational
// so the forwarding unit can share it.
module hazard_detect
  import stall_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              dcd_valid,
  input  logic [REG_AW-1:0] dcd_rs1,
  input  logic [REG_AW-1:0] dcd_rs2,
  input  logic              dcd_rs1_used,
  input  logic              dcd_rs2_used,
  input  logic              exe_valid,
  input  logic              exe_is_load,
  input  logic [REG_AW-1:0] exe_rd,
  output logic              ld_hz
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = dcd_rs1_used && (dcd_rs1 == exe_rd);
  assign rs2_match = dcd_rs2_used && (dcd_rs2 == exe_rd);

  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  assign ld_hz = exe_valid && exe_is_load && (exe_rd != '0) && dcd_valid &&
                 (rs1_match || rs2_match);

endmodule

// File: rtl/stall_ctrl.sv
// Stall controller: merges load-use, multi-cycle and external hold sources
// into a registered active-low stall enable plus a stall-cycle counter.
module stall_ctrl
  import stall_pkg::*;
#(
  parameter int REG_AW  = DEF_REG_AW,
  parameter int MUL_CYC = DEF_MUL_CYC,
  parameter int DIV_CYC = DEF_DIV_CYC,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PERF_W  = DEF_PERF_W
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              dcd_valid,
  input  logic [REG_AW-1:0] dcd_rs1,
  input  logic [REG_AW-1:0] dcd_rs2,
  input  logic              dcd_rs1_used,
  input  logic              dcd_rs2_used,
  input  logic              exe_valid,
  input  logic              exe_is_load,
  input  logic [REG_AW-1:0] exe_rd,
  input  logic              mc_start,
  input  logic              mc_op,
  input  logic              ext_hold_req,
  output logic              ext_hold_ack,
  input  logic              perf_clr,
  output logic              stallb_en,
  output logic [1:0]        stall_state,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYC - 1);

  stall_state_t     state;
  stall_state_t     state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             stallb_nxt;
  logic             ack_nxt;
  logic             ld_hz;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .dcd_valid    (dcd_valid),
    .dcd_rs1      (dcd_rs1),
    .dcd_rs2      (dcd_rs2),
    .dcd_rs1_used (dcd_rs1_used),
    .dcd_rs2_used (dcd_rs2_used),
    .exe_valid    (exe_valid),
    .exe_is_load  (exe_is_load),
    .exe_rd       (exe_rd),
    .ld_hz        (ld_hz)
  );

  // State register; outputs are registered from the next state so they line
  // up with the cycles the FSM actually spends stalled.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      stallb_en    <= 1'b1;
      ext_hold_ack <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      stallb_en    <= stallb_nxt;
      ext_hold_ack <= ack_nxt;
    end
  end

  always_comb begin
    // NOTE: defaulting every combinational output first prevents latches on
    // paths the case arms do not assign.
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (mc_start)          state_nxt = ST_MC;
        else if (ld_hz)        state_nxt = ST_LD;
        else if (ext_hold_req) state_nxt = ST_EXT;
      end
      ST_LD:   state_nxt = ST_IDLE;
      ST_MC:   if (cnt == '0) state_nxt = ST_IDLE;
      ST_EXT:  if (!ext_hold_req) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt    = cnt;
    stallb_nxt = (state_nxt == ST_IDLE);
    ack_nxt    = (state_nxt == ST_EXT);
    if (state == ST_IDLE && mc_start)
      cnt_nxt = (mc_op == MC_OP_DIV) ? DIV_LOAD : MUL_LOAD;
    else if (state == ST_MC && cnt != '0)
      cnt_nxt = cnt - 1'b1;
  end

  assign stall_state = state;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (perf_clr)
      stall_cycles <= '0;
    else if (!stallb_en && stall_cycles != '1)
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule
